// File: rtl/dpmem_fifo.sv
// -----------------------------------------------------------------------------
// dpmem_fifo -- single-clock first-word-fall-through FIFO on a dual-port RAM.
//
// Contents
//   dpmem_ram_wf : write-first dual-port RAM, both ports on one clock, with an
//                  optional extra output register per port (OUTREGA/OUTREGB).
//   dpmem_fifo   : FIFO top. Port A of the RAM is used write-only for pushes,
//                  port B read-only to prefetch the word at the read pointer
//                  into a registered output stage.
//
// dpmem_fifo ports
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   push_valid  in   producer presents push_data
//   push_ready  out  a word can be accepted this cycle (0 while rst is high)
//   push_data   in   word to store
//   pop_valid   out  pop_data holds the oldest stored word
//   pop_ready   in   consumer takes pop_data this cycle
//   pop_data    out  oldest word (first-word-fall-through, registered)
//   count       out  words accepted and not yet popped, 0..2^DEPTH
// -----------------------------------------------------------------------------

module dpmem_ram_wf #(
  parameter int DEPTH   = 10,
  parameter int WIDTH   = 32,
  parameter int OUTREGA = 0,
  parameter int OUTREGB = 0
) (
  input  logic             clk,
  input  logic             a_en_i,
  input  logic             a_we_i,
  input  logic [DEPTH-1:0] a_addr_i,
  input  logic [WIDTH-1:0] a_wdata_i,
  output logic [WIDTH-1:0] a_rdata_o,
  input  logic             b_en_i,
  input  logic             b_we_i,
  input  logic [DEPTH-1:0] b_addr_i,
  input  logic [WIDTH-1:0] b_wdata_i,
  output logic [WIDTH-1:0] b_rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<DEPTH)-1];
  logic [WIDTH-1:0] a_rd_q;
  logic [WIDTH-1:0] b_rd_q;

  // Array update; if both ports write the same address, port B lands last.
  always_ff @(posedge clk) begin
    if (a_en_i && a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    if (b_en_i && b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

  // Port A read: write-first, so a write on either port to this address is
  // returned instead of the old array contents.
  always_ff @(posedge clk) begin
    if (a_en_i) begin
      if (a_we_i) begin
        a_rd_q <= a_wdata_i;
      end else if (b_en_i && b_we_i && (b_addr_i == a_addr_i)) begin
        a_rd_q <= b_wdata_i;
      end else begin
        a_rd_q <= mem_q[a_addr_i];
      end
    end
  end

  // Port B read: write-first, same rule as port A.
  always_ff @(posedge clk) begin
    if (b_en_i) begin
      if (b_we_i) begin
        b_rd_q <= b_wdata_i;
      end else if (a_en_i && a_we_i && (a_addr_i == b_addr_i)) begin
        b_rd_q <= a_wdata_i;
      end else begin
        b_rd_q <= mem_q[b_addr_i];
      end
    end
  end

  generate
    if (OUTREGA != 0) begin : g_outrega
      logic [WIDTH-1:0] a_out_q;
      // Extra pipeline stage on port A read data.
      always_ff @(posedge clk) begin
        a_out_q <= a_rd_q;
      end
      assign a_rdata_o = a_out_q;
    end else begin : g_no_outrega
      assign a_rdata_o = a_rd_q;
    end

    if (OUTREGB != 0) begin : g_outregb
      logic [WIDTH-1:0] b_out_q;
      // Extra pipeline stage on port B read data.
      always_ff @(posedge clk) begin
        b_out_q <= b_rd_q;
      end
      assign b_rdata_o = b_out_q;
    end else begin : g_no_outregb
      assign b_rdata_o = b_rd_q;
    end
  endgenerate

endmodule

module dpmem_fifo #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [DEPTH:0]   count
);

  localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] CNT_ONE  = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] CNT_ZERO = {(DEPTH+1){1'b0}};

  // Architectural state
  logic [DEPTH-1:0] wr_ptr_q,    wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q,    rd_ptr_d;    // next word to move into the output stage
  logic [DEPTH:0]   count_q,     count_d;
  logic             full_q,      full_d;
  logic             pop_valid_q, pop_valid_d;
  logic [WIDTH-1:0] pop_data_q,  pop_data_d;
  logic             prime_q,     prime_d;     // RAM held an unread word before the last edge

  // Combinational helpers
  logic             push_ready_s;
  logic             push_fire_s;
  logic             pop_fire_s;
  logic [DEPTH:0]   mem_cnt_s;     // words in RAM not yet in the output stage
  logic             mem_avail_s;
  logic             load_s;        // move port-B read data into the output stage
  logic [WIDTH-1:0] ram_b_rdata_s;
  logic [WIDTH-1:0] ram_a_rdata_unused;

  // Handshakes, pointer/count next-state and output-stage refill decision.
  //
  // Port B reads rd_ptr_d on every edge, so after any edge its data is the
  // word at rd_ptr_q (write-first covers a push landing on that address the
  // same edge). That data is only trustworthy when the word was counted
  // before the edge, hence refilling is gated on the registered mem_cnt.
  // When the output stage is empty, refilling additionally waits for prime_q
  // so that a word pushed into an empty FIFO appears two edges later; when a
  // pop is taking the current word, the refill is immediate so that
  // back-to-back pops stream one word per cycle.
  always_comb begin
    push_ready_s = ~rst & ~full_q;
    push_fire_s  = push_valid & push_ready_s;
    pop_fire_s   = pop_valid_q & pop_ready;
    mem_cnt_s    = count_q - {{DEPTH{1'b0}}, pop_valid_q};
    mem_avail_s  = (mem_cnt_s != CNT_ZERO);
    load_s       = mem_avail_s & (pop_fire_s | (~pop_valid_q & prime_q));

    wr_ptr_d     = wr_ptr_q + DEPTH'(push_fire_s);
    rd_ptr_d     = rd_ptr_q + DEPTH'(load_s);
    prime_d      = mem_avail_s;

    count_d      = count_q;
    case ({push_fire_s, pop_fire_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d       = (count_d == CAPACITY);

    pop_valid_d  = pop_valid_q;
    pop_data_d   = pop_data_q;
    if (load_s) begin
      pop_valid_d = 1'b1;
      pop_data_d  = ram_b_rdata_s;
    end else if (pop_fire_s) begin
      pop_valid_d = 1'b0;
      pop_data_d  = pop_data_q;
    end else begin
      pop_valid_d = pop_valid_q;
      pop_data_d  = pop_data_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {DEPTH{1'b0}};
      rd_ptr_q    <= {DEPTH{1'b0}};
      count_q     <= CNT_ZERO;
      full_q      <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= {WIDTH{1'b0}};
      prime_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      prime_q     <= prime_d;
    end
  end

  dpmem_ram_wf #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .OUTREGA (0),
    .OUTREGB (0)
  ) u_ram (
    .clk       (clk),
    .a_en_i    (push_fire_s),
    .a_we_i    (push_fire_s),
    .a_addr_i  (wr_ptr_q),
    .a_wdata_i (push_data),
    .a_rdata_o (ram_a_rdata_unused),
    .b_en_i    (1'b1),
    .b_we_i    (1'b0),
    .b_addr_i  (rd_ptr_d),
    .b_wdata_i ({WIDTH{1'b0}}),
    .b_rdata_o (ram_b_rdata_s)
  );

  assign push_ready = push_ready_s;
  assign pop_valid  = pop_valid_q;
  assign pop_data   = pop_data_q;
  assign count      = count_q;

endmodule

// File: tb/tb_dpmem_fifo.sv
// -----------------------------------------------------------------------------
// tb_dpmem_fifo -- self-checking bench for dpmem_fifo (DEPTH=2, WIDTH=32).
// A queue-based reference model tracks accepted words with the edge number at
// which each was accepted; scenario tasks compare the DUT against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dpmem_fifo;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;
  localparam int CAP   = 4;
  localparam int CW    = DEPTH + 1;

  logic             clk;
  logic             rst;
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_valid;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;
  logic [DEPTH:0]   count;

  int n_cmp;
  int n_fail;
  int cyc;

  logic [WIDTH-1:0] ref_data[$];
  int               ref_edge[$];

  dpmem_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; the model accepts what the handshake rules allow.
  task automatic tick();
    bit               do_push;
    bit               do_pop;
    logic [WIDTH-1:0] d;
    do_push = push_valid && (ref_data.size() < CAP) && !rst;
    do_pop  = pop_ready && pop_valid && (ref_data.size() > 0) && !rst;
    d       = push_data;
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(ref_data.pop_front());
      void'(ref_edge.pop_front());
    end
    if (do_push) begin
      ref_data.push_back(d);
      ref_edge.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic drain();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    repeat (8) tick();
    pop_ready  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    ref_data.delete(); ref_edge.delete();
    repeat (2) tick();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
    n_cmp++; if (pop_data !== 32'h0) begin n_fail++; $display("FAIL reset_pop_data: got %h want 0", pop_data); end
    n_cmp++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL reset_push_ready_held: got %b want 0", push_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready_release: got %b want 1", push_ready); end
    push_valid = 1'b1; push_data = 32'h0000BEEF;
    tick();
    push_valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL first_push_after_reset: count %0d want 1", count); end
    drain();
  endtask

  task automatic test_latency();
    pop_ready = 1'b0; push_valid = 1'b1; push_data = 32'hA0000001;
    tick();
    push_valid = 1'b0;
    tick();
    n_cmp++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL latency_k1: pop_valid %b want 0", pop_valid); end
    tick();
    n_cmp++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL latency_k2_valid: pop_valid %b want 1", pop_valid); end
    n_cmp++; if (pop_data !== 32'hA0000001) begin n_fail++; $display("FAIL latency_k2_data: got %h want a0000001", pop_data); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL latency_count: got %0d want 1", count); end
    drain();
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] exp_w;
    pop_ready = 1'b0; push_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_data = WIDTH'(i);
      tick();
    end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    n_cmp++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL fill_push_ready: got %b want 0", push_ready); end
    push_data = 32'h5;
    tick();
    push_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_extra_ignored: count %0d want 4", count); end
    pop_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_w = WIDTH'(i);
      n_cmp++;
      if (pop_valid !== 1'b1 || pop_data !== exp_w) begin
        n_fail++; $display("FAIL fill_pop_order: valid %b data %h want valid 1 data %h", pop_valid, pop_data, exp_w);
      end
      tick();
    end
    pop_ready = 1'b0;
    n_cmp++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty_valid: got %b want 0", pop_valid); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_empty_count: got %0d want 0", count); end
  endtask

  task automatic test_full_push_pop();
    pop_ready = 1'b0; push_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data = $urandom();
      tick();
    end
    push_data = 32'hDEAD0005; pop_ready = 1'b1;
    tick();
    push_valid = 1'b0; pop_ready = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pushpop_count: got %0d want 3", count); end
    n_cmp++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_ready: got %b want 1", push_ready); end
    n_cmp++;
    if (pop_valid !== 1'b1 || ref_data.size() != 3 || pop_data !== ref_data[0]) begin
      n_fail++; $display("FAIL full_pushpop_head: valid %b data %h model_size %0d", pop_valid, pop_data, ref_data.size());
    end
    drain();
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] got[$];
    bit               started;
    started = 1'b0;
    pop_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (t == 0) begin
        push_valid = 1'b1; push_data = 32'd0;
      end else if (t >= 2 && t <= 20) begin
        push_valid = 1'b1; push_data = WIDTH'(t - 1);
      end else begin
        push_valid = 1'b0;
      end
      tick();
      n_cmp++; if (count > 3'd2) begin n_fail++; $display("FAIL stream_count_bound: t %0d count %0d want <=2", t, count); end
      if (t == 2) begin
        n_cmp++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL stream_first_valid: got %b want 1", pop_valid); end
      end
      if (pop_valid === 1'b1) begin
        got.push_back(pop_data);
        started = 1'b1;
      end else if (started && got.size() < 20) begin
        n_cmp++; n_fail++;
        $display("FAIL stream_bubble: t %0d pop_valid 0 after %0d words", t, got.size());
      end
    end
    pop_ready = 1'b0;
    n_cmp++; if (got.size() != 20) begin n_fail++; $display("FAIL stream_word_count: got %0d want 20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== WIDTH'(i)) begin n_fail++; $display("FAIL stream_order: idx %0d got %h want %h", i, got[i], WIDTH'(i)); end
    end
  endtask

  task automatic test_stall();
    pop_ready = 1'b0; push_valid = 1'b1;
    push_data = 32'h11223344; tick();
    push_data = 32'h55667788; tick();
    push_valid = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (pop_valid !== 1'b1 || pop_data !== 32'h11223344) begin
        n_fail++; $display("FAIL stall_hold: cycle %0d valid %b data %h want 1 11223344", s, pop_valid, pop_data);
      end
      tick();
    end
    n_cmp++; if (pop_data !== 32'h11223344) begin n_fail++; $display("FAIL stall_release_first: got %h want 11223344", pop_data); end
    pop_ready = 1'b1;
    tick();
    n_cmp++;
    if (pop_valid !== 1'b1 || pop_data !== 32'h55667788) begin
      n_fail++; $display("FAIL stall_release_second: valid %b data %h want 1 55667788", pop_valid, pop_data);
    end
    tick();
    n_cmp++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_empty: got %b want 0", pop_valid); end
    pop_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    pop_ready = 1'b0; push_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_data = $urandom() | 32'h1;
      tick();
    end
    push_data = 32'h12345678;
    #2 rst = 1'b1;
    #1;
    ref_data.delete(); ref_edge.delete();
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", pop_valid); end
    n_cmp++; if (pop_data !== 32'h0) begin n_fail++; $display("FAIL midreset_data: got %h want 0", pop_data); end
    tick();
    rst = 1'b0;
    push_data = 32'hCAFEDECA; pop_ready = 1'b1;
    tick();
    push_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 6 && !found; t++) begin
      if (pop_valid === 1'b1) begin
        found = 1'b1;
        n_cmp++; if (pop_data !== 32'hCAFEDECA) begin n_fail++; $display("FAIL midreset_first_word: got %h want cafedeca", pop_data); end
      end else begin
        tick();
      end
    end
    if (!found) begin
      n_cmp++; n_fail++; $display("FAIL midreset_timeout: pop_valid never rose");
    end
    drain();
  endtask

  task automatic test_random();
    bit               prev_pv;
    bit               prev_pr;
    logic [WIDTH-1:0] prev_data;
    int               prev_size;
    int               pr_pct;
    for (int i = 0; i < 400; i++) begin
      pr_pct     = ((i / 100) % 2 == 0) ? 3 : 7;
      push_valid = ($urandom_range(0, 9) < 6);
      push_data  = $urandom();
      pop_ready  = ($urandom_range(0, 9) < pr_pct);
      prev_pv    = pop_valid;
      prev_pr    = pop_ready;
      prev_data  = pop_data;
      prev_size  = ref_data.size();
      tick();
      n_cmp++; if (count !== CW'(ref_data.size())) begin n_fail++; $display("FAIL rand_count: i %0d got %0d want %0d", i, count, ref_data.size()); end
      n_cmp++; if (push_ready !== (ref_data.size() < CAP)) begin n_fail++; $display("FAIL rand_push_ready: i %0d got %b size %0d", i, push_ready, ref_data.size()); end
      if (ref_data.size() == 0) begin
        n_cmp++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty_valid: i %0d got %b want 0", i, pop_valid); end
      end else begin
        if (pop_valid === 1'b1) begin
          n_cmp++; if (pop_data !== ref_data[0]) begin n_fail++; $display("FAIL rand_head_data: i %0d got %h want %h", i, pop_data, ref_data[0]); end
        end
        if (cyc - ref_edge[0] >= 3) begin
          n_cmp++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL rand_head_latency: i %0d pop_valid %b want 1", i, pop_valid); end
        end
      end
      if (prev_pv && !prev_pr) begin
        n_cmp++;
        if (pop_valid !== 1'b1 || pop_data !== prev_data) begin
          n_fail++; $display("FAIL rand_stall_hold: i %0d valid %b data %h want 1 %h", i, pop_valid, pop_data, prev_data);
        end
      end
      if (prev_pv && prev_pr && prev_size >= 2) begin
        n_cmp++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL rand_back_to_back: i %0d pop_valid %b want 1", i, pop_valid); end
      end
    end
    drain();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    test_reset();
    test_latency();
    test_fill();
    test_full_push_pop();
    test_stream();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
